fft_sdf_stage_ctrl: RTL and testbench

//  Sequencer for one radix-2 single-path-delay-feedback (R2SDF) stage of the 32-point FFT pipeline.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_twiddle_rom32.sv | 20 ++
 rtl/fft_sdf_stage_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fft_sdf_stage_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Package: fft_pkg
// Shared constants and the stage-sequencer FSM state type for the
// 32-point radix-2 SDF FFT pipeline.
package fft_pkg;

  localparam int unsigned N     = 32;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned TW_W  = 8;

  // +1.0 in signed (2,6) format
  localparam logic [TW_W-1:0] W_ONE_R = 8'h40;
  localparam logic [TW_W-1:0] W_ONE_I = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    RUN   = 2'b10,
    FLUSH = 2'b11
  } sdf_state_t;

endpackage

// File: rtl/fft_twiddle_rom32.sv
// Module: fft_twiddle_rom32
// Combinational table of W_32^k = (cos, -sin)(2*pi*k/32) * 64, k = 0..15,
// rounded to nearest with ties away from zero. Registered by the caller.
module fft_twiddle_rom32 #(
  parameter int unsigned TW_W = 8
) (
  input  logic [3:0]      k_i,
  output logic [TW_W-1:0] wn_r_o,
  output logic [TW_W-1:0] wn_i_o
);

  localparam int COS_T [16] = '{ 64,  63,  59,  53,  45,  36,  24,  12,
                                  0, -12, -24, -36, -45, -53, -59, -63};
  localparam int MSIN_T [16] = '{  0, -12, -24, -36, -45, -53, -59, -63,
                                 -64, -63, -59, -53, -45, -36, -24, -12};

  assign wn_r_o = TW_W'(COS_T[k_i]);
  assign wn_i_o = TW_W'(MSIN_T[k_i]);

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Module: fft_sdf_stage_ctrl
// Sequencer for one R2SDF stage of the 32-point FFT: tracks each sample's
// index in its frame and issues registered data, SR enable, butterfly/fill
// mode, output valid, twiddle and a misplaced-last error pulse.
// Optional macro FFT_CTRL_FRAME_CNT_EN adds a saturating frame counter port.
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned DELAY  = 8,
  parameter int unsigned TW_W   = fft_pkg::TW_W,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_in_r,
  input  logic [DATA_W-1:0] data_in_i,
  output logic [DATA_W-1:0] data_out_r,
  output logic [DATA_W-1:0] data_out_i,
  output logic              sr_en,
  output logic              bf_mode,
  output logic              valid_o,
  output logic [TW_W-1:0]   WN_r,
  output logic [TW_W-1:0]   WN_i,
  output logic              err_o
`ifdef FFT_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt_o
`endif
);

  localparam int unsigned      LOG2D     = $clog2(DELAY);
  localparam int unsigned      K_SHIFT   = 4 - LOG2D;
  localparam logic [3:0]       Q_MASK    = 4'(DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DELAY - 1);

  sdf_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] dr_q, dr_d, di_q, di_d;
  logic              sr_en_q, sr_en_d;
  logic              bf_q, bf_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [TW_W-1:0]   wr_q, wr_d, wi_q, wi_d;
  logic [3:0]        k;
  logic [TW_W-1:0]   rom_r, rom_i;

  // k = (idx mod D) * (16/D); D is a power of two so this is mask-and-shift
  assign k = (idx_q[3:0] & Q_MASK) << K_SHIFT;

  fft_twiddle_rom32 #(.TW_W(TW_W)) u_rom (
    .k_i    (k),
    .wn_r_o (rom_r),
    .wn_i_o (rom_i)
  );

  // Next state and next output values; idle/stall cycles hold data, bf and idx
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dr_d    = dr_q;
    di_d    = di_q;
    sr_en_d = 1'b0;
    bf_d    = bf_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    wr_d    = '0;
    wi_d    = '0;
    if (state_q == FLUSH) begin
      // Self-generated drain cycles: zero data, fill mode, twiddles follow idx
      sr_en_d = 1'b1;
      vld_d   = 1'b1;
      bf_d    = 1'b0;
      dr_d    = '0;
      di_d    = '0;
      wr_d    = rom_r;
      wi_d    = rom_i;
      if (idx_q == IDX_DLAST) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (valid_i) begin
      sr_en_d = 1'b1;
      dr_d    = data_in_r;
      di_d    = data_in_i;
      bf_d    = idx_q[LOG2D];
      vld_d   = (state_q == RUN);
      idx_d   = idx_q + IDX_W'(1);
      err_d   = last_i && !((state_q == RUN) && (idx_q == IDX_LAST));
      if (bf_d) begin
        wr_d = TW_W'(W_ONE_R);
        wi_d = TW_W'(W_ONE_I);
      end else if (vld_d) begin
        wr_d = rom_r;
        wi_d = rom_i;
      end
      case (state_q)
        IDLE, FILL: state_d = (idx_q == IDX_DLAST) ? RUN : FILL;
        RUN:        if (last_i && (idx_q == IDX_LAST)) state_d = FLUSH;
        default:    ;
      endcase
    end
  end

  // State and output registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dr_q    <= '0;
      di_q    <= '0;
      sr_en_q <= 1'b0;
      bf_q    <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      wi_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dr_q    <= dr_d;
      di_q    <= di_d;
      sr_en_q <= sr_en_d;
      bf_q    <= bf_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      wi_q    <= wi_d;
    end
  end

  assign data_out_r = dr_q;
  assign data_out_i = di_q;
  assign sr_en      = sr_en_q;
  assign bf_mode    = bf_q;
  assign valid_o    = vld_q;
  assign WN_r       = wr_q;
  assign WN_i       = wi_q;
  assign err_o      = err_q;

`ifdef FFT_CTRL_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Count issued valid outputs carrying idx 31, saturating
  always_comb begin
    fcnt_d = fcnt_q;
    if (vld_d && (idx_q == IDX_LAST) && (fcnt_q != '1)) fcnt_d = fcnt_q + 16'd1;
  end

  // Frame counter register; persists across IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fcnt_q <= '0;
    else      fcnt_q <= fcnt_d;
  end

  assign frame_cnt_o = fcnt_q;
`endif

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Testbench: tb_fft_sdf_stage_ctrl
// Table-driven directed checks plus randomized streams against a
// behavioural model for fft_sdf_stage_ctrl with DELAY=8.
module tb_fft_sdf_stage_ctrl;

  localparam int D  = 8;
  localparam int DW = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic [DW-1:0] data_in_r = '0;
  logic [DW-1:0] data_in_i = '0;
  logic [DW-1:0] data_out_r, data_out_i;
  logic          sr_en, bf_mode, valid_o, err_o;
  logic [TW-1:0] WN_r, WN_i;
`ifdef FFT_CTRL_FRAME_CNT_EN
  logic [15:0]   frame_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;

  always #5 clk = ~clk;

  fft_sdf_stage_ctrl #(.DELAY(D), .TW_W(TW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i),
    .sr_en      (sr_en),
    .bf_mode    (bf_mode),
    .valid_o    (valid_o),
    .WN_r       (WN_r),
    .WN_i       (WN_i),
    .err_o      (err_o)
`ifdef FFT_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt_o(frame_cnt_o)
`endif
  );

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  int m_n, m_fidx, m_frames;
  bit m_flushing;
  int e_sr, e_vld, e_bf, e_err, e_dr, e_di, e_wr, e_wi;

  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic void tw_ref(int k, output int r, output int i);
    real a;
    a = 2.0 * 3.14159265358979 * k / 32.0;
    r = rnd($cos(a) * 64.0);
    i = rnd(-$sin(a) * 64.0);
  endfunction

  function automatic void model_reset();
    m_n = 0; m_fidx = 0; m_frames = 0; m_flushing = 0;
    e_sr = 0; e_vld = 0; e_bf = 0; e_err = 0;
    e_dr = 0; e_di = 0; e_wr = 0; e_wi = 0;
  endfunction

  function automatic void model_step(bit v, bit l, int dr, int di);
    int idx;
    if (m_flushing) begin
      e_sr = 1; e_vld = 1; e_bf = 0; e_err = 0; e_dr = 0; e_di = 0;
      tw_ref((m_fidx % D) * (16 / D), e_wr, e_wi);
      m_fidx++;
      if (m_fidx == D) begin
        m_flushing = 0;
        m_n = 0;
      end
    end else if (v) begin
      idx   = m_n % 32;
      e_sr  = 1; e_dr = dr; e_di = di;
      e_vld = (m_n >= D) ? 1 : 0;
      e_bf  = (idx / D) % 2;
      e_err = (l && !(e_vld == 1 && idx == 31)) ? 1 : 0;
      if (e_vld == 0) begin
        e_wr = 0; e_wi = 0;
      end else if (e_bf == 1) begin
        e_wr = 64; e_wi = 0;
      end else begin
        tw_ref((idx % D) * (16 / D), e_wr, e_wi);
      end
      if (e_vld == 1 && idx == 31 && m_frames < 65535) m_frames++;
      if (l && e_vld == 1 && idx == 31) begin
        m_flushing = 1;
        m_fidx = 0;
      end else begin
        m_n++;
      end
    end else begin
      e_sr = 0; e_vld = 0; e_err = 0;
    end
  endfunction

  task automatic compare_all(string tag);
    chk({tag, ".sr_en"},   int'(sr_en),      e_sr);
    chk({tag, ".valid_o"}, int'(valid_o),    e_vld);
    chk({tag, ".bf_mode"}, int'(bf_mode),    e_bf);
    chk({tag, ".err_o"},   int'(err_o),      e_err);
    chk({tag, ".data_r"},  int'(data_out_r), e_dr);
    chk({tag, ".data_i"},  int'(data_out_i), e_di);
    if (e_vld == 1) begin
      chk({tag, ".WN_r"}, int'($signed(WN_r)), e_wr);
      chk({tag, ".WN_i"}, int'($signed(WN_i)), e_wi);
    end
`ifdef FFT_CTRL_FRAME_CNT_EN
    chk({tag, ".frame_cnt"}, int'(frame_cnt_o), m_frames);
`endif
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".sr_en"},   int'(sr_en),      0);
    chk({tag, ".valid_o"}, int'(valid_o),    0);
    chk({tag, ".bf_mode"}, int'(bf_mode),    0);
    chk({tag, ".err_o"},   int'(err_o),      0);
    chk({tag, ".data_r"},  int'(data_out_r), 0);
    chk({tag, ".data_i"},  int'(data_out_i), 0);
    chk({tag, ".WN_r"},    int'(WN_r),       0);
    chk({tag, ".WN_i"},    int'(WN_i),       0);
`ifdef FFT_CTRL_FRAME_CNT_EN
    chk({tag, ".frame_cnt"}, int'(frame_cnt_o), 0);
`endif
  endtask

  // Drive one cycle's inputs, advance the model, compare after the edge
  task automatic step(input bit v, input bit l, input logic [7:0] dr,
                      input logic [7:0] di, input string tag);
    valid_i = v; last_i = l; data_in_r = dr; data_in_i = di;
    model_step(v, l, int'(dr), int'(di));
    @(posedge clk);
    #1;
    compare_all(tag);
    if (valid_o) vcnt++;
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic do_reset(string tag);
    rst = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    int cyc;
    int bf;
    int vld;
    int wr;
    int wi;
  } vec_t;

  vec_t tbl [23];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Expected outputs for D=8 indexed by cycle of a 32-accept stream + flush
    tbl = '{'{ 0, 0, 0,   0,   0}, '{ 5, 0, 0,   0,   0}, '{ 7, 0, 0,   0,   0},
            '{ 8, 1, 1,  64,   0}, '{12, 1, 1,  64,   0}, '{15, 1, 1,  64,   0},
            '{16, 0, 1,  64,   0}, '{17, 0, 1,  59, -24}, '{18, 0, 1,  45, -45},
            '{19, 0, 1,  24, -59}, '{21, 0, 1, -24, -59}, '{23, 0, 1, -59, -24},
            '{24, 1, 1,  64,   0}, '{26, 1, 1,  64,   0}, '{31, 1, 1,  64,   0},
            '{32, 0, 1,  64,   0}, '{33, 0, 1,  59, -24}, '{34, 0, 1,  45, -45},
            '{35, 0, 1,  24, -59}, '{36, 0, 1,   0, -64}, '{37, 0, 1, -24, -59},
            '{38, 0, 1, -45, -45}, '{39, 0, 1, -59, -24}};

    // 1. reset: outputs stay zero while valid_i toggles, nothing after release
    model_reset();
    #1;
    check_zero("t1_rst");
    for (int i = 0; i < 3; i++) begin
      valid_i = ~valid_i;
      data_in_r = 8'($urandom);
      @(posedge clk);
      #1;
      check_zero("t1_rst_hold");
    end
    valid_i = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, "t1_idle");

    // 2/3. one contiguous frame with last_i on the 32nd sample, then flush
    vcnt = 0;
    for (int c = 0; c < 41; c++) begin
      if (c < 32) step(1, c == 31, 8'($urandom), 8'($urandom), "t2");
      else        step(0, 0, 8'h00, 8'h00, "t2");
      for (int j = 0; j < 23; j++) begin
        if (tbl[j].cyc == c) begin
          chk("t2_tbl_bf",   int'(bf_mode), tbl[j].bf);
          chk("t2_tbl_vld",  int'(valid_o), tbl[j].vld);
          chk("t2_tbl_WN_r", int'($signed(WN_r)), tbl[j].wr);
          chk("t2_tbl_WN_i", int'($signed(WN_i)), tbl[j].wi);
        end
      end
    end
    chk("t2_total_valid", vcnt, 32);

    // 4. stall three cycles after idx 12; 5. misplaced last_i at idx 20 of frame 2
    vcnt = 0;
    for (int i = 0; i < 13; i++) step(1, 0, 8'($urandom), 8'($urandom), "t4");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 8'h00, "t4_stall");
      chk("t4_stall_sr_en", int'(sr_en), 0);
      chk("t4_stall_valid", int'(valid_o), 0);
    end
    step(1, 0, 8'h5a, 8'ha5, "t4_idx13");
    chk("t4_idx13_bf", int'(bf_mode), 1);
    chk("t4_idx13_valid", int'(valid_o), 1);
    for (int i = 14; i < 64; i++) begin
      step(1, (i == 52) || (i == 63), 8'($urandom), 8'($urandom), "t5");
      if (i == 52) chk("t5_err_pulse", int'(err_o), 1);
      if (i == 53) begin
        chk("t5_err_clear", int'(err_o), 0);
        chk("t5_still_run", int'(valid_o), 1);
      end
    end
    for (int i = 0; i < D + 1; i++) step(0, 0, 8'h00, 8'h00, "t5_flush");
    chk("t5_total_valid", vcnt, 64);

    // 6. reset during the third flush cycle, then a fresh stream refills
    for (int i = 0; i < 32; i++) step(1, i == 31, 8'($urandom), 8'($urandom), "t6");
    step(0, 0, 8'h00, 8'h00, "t6_flush");
    step(0, 0, 8'h00, 8'h00, "t6_flush");
    #2;
    do_reset("t6_rst");
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'($urandom), 8'($urandom), "t6_refill");
      if (i == 7) chk("t6_fill_no_valid", vcnt, 0);
    end
    chk("t6_refill_valid", vcnt, 2);

    // Randomized streams with gaps and stray last_i
    #2;
    do_reset("rnd_rst");
    for (int s = 0; s < 6; s++) begin
      int frames;
      int gap;
      bit l;
      frames = int'($urandom_range(1, 3));
      vcnt = 0;
      for (int i = 0; i < 32 * frames; i++) begin
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        for (int g = 0; g < gap; g++) step(0, 0, 8'h00, 8'h00, "rnd_gap");
        l = (i == 32 * frames - 1) || ((i % 32 != 31) && ($urandom_range(0, 15) == 0));
        step(1, l, 8'($urandom), 8'($urandom), "rnd");
      end
      for (int i = 0; i < D + 2; i++) step(0, 0, 8'h00, 8'h00, "rnd_flush");
      chk("rnd_total_valid", vcnt, 32 * frames);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
